// File: rtl/pc_update_unit.sv
// Architectural PC register stage: loads the jump-select mux output, replays redirects caught during stalls.
// Optional applied-redirect counter enabled by defining PC_REDIRECT_CNT_EN.
module pc_update_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] Jump_Output,
  input  logic                Redirect,
  input  logic                Stall,
  input  logic                Halt,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] PCPlus4,
  output logic                PC_Valid,
  output logic                Flush,
  output logic                Halted,
  output logic                Misaligned,
  output logic [31:0]         Redirect_Count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [PC_WIDTH-1:0] RESET_PC_W = RESET_PC[PC_WIDTH-1:0];

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc_q, pc_next;
  logic [PC_WIDTH-1:0] pending_q, pending_next;
  logic                flush_q, flush_next;
  logic                mis_q, mis_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      pc_q      <= RESET_PC_W;
      pending_q <= '0;
      flush_q   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state     <= state_next;
      pc_q      <= pc_next;
      pending_q <= pending_next;
      flush_q   <= flush_next;
      mis_q     <= mis_next;
    end
  end

  // Loads always strip bits [1:0]; the misaligned flag reports the raw source.
  always_comb begin
    state_next   = state;
    pc_next      = pc_q;
    pending_next = pending_q;
    flush_next   = 1'b0;
    mis_next     = 1'b0;
    unique case (state)
      BOOT: begin
        state_next = RUN;
        pc_next    = RESET_PC_W;
      end
      RUN: begin
        if (Halt) begin
          state_next = HALT;
        end else if (Stall) begin
          if (Redirect) begin
            pending_next = Jump_Output;
            state_next   = HOLD;
          end
        end else begin
          pc_next    = {Jump_Output[PC_WIDTH-1:2], 2'b00};
          flush_next = Redirect;
          mis_next   = |Jump_Output[1:0];
        end
      end
      HOLD: begin
        if (Halt) begin
          state_next   = HALT;
          pending_next = '0;
        end else if (!Stall) begin
          pc_next      = {pending_q[PC_WIDTH-1:2], 2'b00};
          flush_next   = 1'b1;
          mis_next     = |pending_q[1:0];
          pending_next = '0;
          state_next   = RUN;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  assign PC         = pc_q;
  assign PCPlus4    = pc_q + PC_WIDTH'(4);
  assign PC_Valid   = (state == RUN) || (state == HOLD);
  assign Halted     = (state == HALT);
  assign Flush      = flush_q;
  assign Misaligned = mis_q;

`ifdef PC_REDIRECT_CNT_EN
  logic [31:0] cnt_q;

  // Counts on the same edge that raises Flush, so the two stay in step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (flush_next && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign Redirect_Count = cnt_q;
`else
  assign Redirect_Count = '0;
`endif

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed self-checking bench for pc_update_unit with hand-computed expected values.
module tb_pc_update_unit;

  logic        clk;
  logic        rst;
  logic [31:0] Jump_Output;
  logic        Redirect;
  logic        Stall;
  logic        Halt;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        PC_Valid;
  logic        Flush;
  logic        Halted;
  logic        Misaligned;
  logic [31:0] Redirect_Count;

  int unsigned checks;
  int unsigned failures;
  logic [31:0] exp_cnt2;

  pc_update_unit #(
    .RESET_PC(32'h0000_0000),
    .PC_WIDTH(32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .Jump_Output   (Jump_Output),
    .Redirect      (Redirect),
    .Stall         (Stall),
    .Halt          (Halt),
    .PC            (PC),
    .PCPlus4       (PCPlus4),
    .PC_Valid      (PC_Valid),
    .Flush         (Flush),
    .Halted        (Halted),
    .Misaligned    (Misaligned),
    .Redirect_Count(Redirect_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] j, input logic r, input logic s, input logic h);
    Jump_Output = j;
    Redirect    = r;
    Stall       = s;
    Halt        = h;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
`ifdef PC_REDIRECT_CNT_EN
    exp_cnt2 = 32'd2;
`else
    exp_cnt2 = 32'd0;
`endif
    rst = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    cyc();
    cyc();
    check_eq("rst_pc", PC, 32'h0);
    check_eq("rst_valid", {31'b0, PC_Valid}, 32'd0);
    check_eq("rst_flush", {31'b0, Flush}, 32'd0);
    check_eq("rst_halted", {31'b0, Halted}, 32'd0);
    check_eq("rst_mis", {31'b0, Misaligned}, 32'd0);
    check_eq("rst_cnt", Redirect_Count, 32'd0);

    // BOOT: first cycle after release, input ignored
    rst = 1'b0;
    drive(32'h4, 1'b0, 1'b0, 1'b0);
    check_eq("boot_valid", {31'b0, PC_Valid}, 32'd0);
    cyc();
    check_eq("run0_pc", PC, 32'h0);
    check_eq("run0_valid", {31'b0, PC_Valid}, 32'd1);
    for (int unsigned i = 1; i <= 4; i++) begin
      drive(32'(i * 4), 1'b0, 1'b0, 1'b0);
      cyc();
      check_eq("seq_pc", PC, 32'(i * 4));
      check_eq("seq_flush", {31'b0, Flush}, 32'd0);
    end
    check_eq("seq_plus4", PCPlus4, 32'h14);

    // Unstalled redirect at PC=0x10
    drive(32'h200, 1'b1, 1'b0, 1'b0);
    cyc();
    check_eq("redir_pc", PC, 32'h200);
    check_eq("redir_flush", {31'b0, Flush}, 32'd1);
    drive(32'h204, 1'b0, 1'b0, 1'b0);
    cyc();
    check_eq("redir_pc2", PC, 32'h204);
    check_eq("redir_flush2", {31'b0, Flush}, 32'd0);

    // Redirects during a 3-cycle stall: first target wins
    drive(32'h400, 1'b1, 1'b1, 1'b0);
    cyc();
    check_eq("stall1_pc", PC, 32'h204);
    check_eq("stall1_flush", {31'b0, Flush}, 32'd0);
    check_eq("stall1_valid", {31'b0, PC_Valid}, 32'd1);
    drive(32'h800, 1'b1, 1'b1, 1'b0);
    cyc();
    check_eq("stall2_pc", PC, 32'h204);
    drive(32'h208, 1'b0, 1'b1, 1'b0);
    cyc();
    check_eq("stall3_pc", PC, 32'h204);
    check_eq("stall3_flush", {31'b0, Flush}, 32'd0);
    drive(32'h208, 1'b0, 1'b0, 1'b0);
    cyc();
    check_eq("replay_pc", PC, 32'h400);
    check_eq("replay_flush", {31'b0, Flush}, 32'd1);
    drive(32'h404, 1'b0, 1'b0, 1'b0);
    cyc();
    check_eq("replay_pc2", PC, 32'h404);
    check_eq("replay_flush2", {31'b0, Flush}, 32'd0);
    check_eq("cnt_mid", Redirect_Count, exp_cnt2);

    // Halt beats Stall and Redirect
    drive(32'h20, 1'b1, 1'b0, 1'b0);
    cyc();
    check_eq("to20_pc", PC, 32'h20);
    drive(32'h300, 1'b1, 1'b1, 1'b1);
    cyc();
    check_eq("halt_halted", {31'b0, Halted}, 32'd1);
    check_eq("halt_valid", {31'b0, PC_Valid}, 32'd0);
    check_eq("halt_pc", PC, 32'h20);
    for (int unsigned i = 0; i < 3; i++) begin
      drive(32'h300 + 32'(i * 16), 1'(i), 1'b0, 1'(i));
      cyc();
      check_eq("halt_hold_pc", PC, 32'h20);
      check_eq("halt_hold_flush", {31'b0, Flush}, 32'd0);
      check_eq("halt_hold_halted", {31'b0, Halted}, 32'd1);
    end
    rst = 1'b1;
    cyc();
    check_eq("rst2_pc", PC, 32'h0);
    check_eq("rst2_halted", {31'b0, Halted}, 32'd0);
    check_eq("rst2_valid", {31'b0, PC_Valid}, 32'd0);
    check_eq("rst2_cnt", Redirect_Count, 32'd0);
    rst = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    cyc();
    check_eq("boot2_pc", PC, 32'h0);
    check_eq("boot2_valid", {31'b0, PC_Valid}, 32'd1);

    // Misaligned target and PCPlus4 wrap
    drive(32'h103, 1'b1, 1'b0, 1'b0);
    cyc();
    check_eq("mis_pc", PC, 32'h100);
    check_eq("mis_flag", {31'b0, Misaligned}, 32'd1);
    check_eq("mis_flush", {31'b0, Flush}, 32'd1);
    drive(32'h104, 1'b0, 1'b0, 1'b0);
    cyc();
    check_eq("mis_pc2", PC, 32'h104);
    check_eq("mis_flag2", {31'b0, Misaligned}, 32'd0);
    drive(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    cyc();
    check_eq("wrap_pc", PC, 32'hFFFF_FFFC);
    check_eq("wrap_plus4", PCPlus4, 32'h0);
    check_eq("wrap_cnt", Redirect_Count, exp_cnt2);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    cyc();
    check_eq("wrap_pc2", PC, 32'h0);
    check_eq("wrap_flush2", {31'b0, Flush}, 32'd0);

    // Halt while holding a pending target drops it
    drive(32'h500, 1'b1, 1'b1, 1'b0);
    cyc();
    check_eq("hh_pc", PC, 32'h0);
    drive(32'h600, 1'b0, 1'b1, 1'b1);
    cyc();
    check_eq("hh_halted", {31'b0, Halted}, 32'd1);
    drive(32'h700, 1'b0, 1'b0, 1'b0);
    cyc();
    check_eq("hh_pc2", PC, 32'h0);
    check_eq("hh_flush", {31'b0, Flush}, 32'd0);
    check_eq("hh_valid", {31'b0, PC_Valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
